// File: rtl/cv32e41p_instr_obi_arbiter.sv
// Two-master arbiter sharing one OBI instruction port.
// Each granted transaction records its owner so its response is routed back to that master.
module cv32e41p_instr_obi_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned ARB_MODE        = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req_i,
   input  logic        m1_req_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m1_addr_i,
   output logic        m0_gnt_o,
   output logic        m1_gnt_o,
   output logic        m0_rvalid_o,
   output logic        m1_rvalid_o,
   output logic        m0_err_o,
   output logic        m1_err_o,
   output logic [31:0] m_rdata_o,
   output logic        obi_req_o,
   output logic [31:0] obi_addr_o,
   input  logic        obi_gnt_i,
   input  logic        obi_rvalid_i,
   input  logic [31:0] obi_rdata_i,
   input  logic        obi_err_i,
   output logic        busy_o
);

   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
   logic [PTR_W-1:0]           wptr_q, wptr_d;
   logic [PTR_W-1:0]           rptr_q, rptr_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       lock_q, lock_d;
   logic                       lock_id_q, lock_id_d;
   logic                       last_q, last_d;

   logic sel, req_sel, full, empty, push, pop, head, req_out;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      sel = 1'b0;
      if (lock_q) begin
         sel = lock_id_q;
      end else if (ARB_MODE == 0) begin
         sel = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
      end else begin
         sel = ~m0_req_i;
      end
   end

   assign req_sel = sel ? m1_req_i : m0_req_i;
   assign full    = (cnt_q == CNT_MAX);
   assign empty   = (cnt_q == '0);
   // Full gates on the registered count only, so rvalid never reaches obi_req_o.
   assign req_out = req_sel && !full && !rst;
   assign push    = req_out && obi_gnt_i;
   assign pop     = obi_rvalid_i && !empty && !rst;
   assign head    = fifo_q[rptr_q];

   always_comb begin
      fifo_d = fifo_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) begin
         fifo_d[wptr_q] = sel;
         wptr_d         = ptr_inc(wptr_q);
      end
      if (pop) begin
         rptr_d = ptr_inc(rptr_q);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      // Hold the selection for any pending address phase, whether waiting on gnt or on space.
      lock_d    = req_sel && !push;
      lock_id_d = lock_d ? sel : lock_id_q;
      last_d    = push ? sel : last_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_q    <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         fifo_q    <= fifo_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         last_q    <= last_d;
      end
   end

   assign obi_req_o   = req_out;
   assign obi_addr_o  = rst ? 32'h0 : (sel ? m1_addr_i : m0_addr_i);
   assign m0_gnt_o    = push && !sel;
   assign m1_gnt_o    = push && sel;
   assign m0_rvalid_o = pop && !head;
   assign m1_rvalid_o = pop && head;
   assign m0_err_o    = m0_rvalid_o && obi_err_i;
   assign m1_err_o    = m1_rvalid_o && obi_err_i;
   assign m_rdata_o   = rst ? 32'h0 : obi_rdata_i;
   assign busy_o      = !rst && (!empty || req_out);

endmodule

// File: tb/tb_cv32e41p_instr_obi_arbiter.sv
// Scoreboard bench for the two-master instruction OBI arbiter.
module tb_cv32e41p_instr_obi_arbiter;

   localparam logic [31:0] A0 = 32'h0000_1000;
   localparam logic [31:0] A1 = 32'h0000_2004;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req_i, m1_req_i;
   logic [31:0] m0_addr_i, m1_addr_i;
   logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
   logic [31:0] m_rdata_o;
   logic        obi_req_o;
   logic [31:0] obi_addr_o;
   logic        obi_gnt_i, obi_rvalid_i, obi_err_i;
   logic [31:0] obi_rdata_i;
   logic        busy_o;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct { logic id; logic [31:0] addr; } gnt_t;
   typedef struct { logic vld; logic id; logic err; logic [31:0] data; } rsp_t;
   gnt_t gnt_q[$];
   rsp_t rsp_q[$];

   always #5 clk = ~clk;

   cv32e41p_instr_obi_arbiter #(.MAX_OUTSTANDING(2), .ARB_MODE(0)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req_i), .m1_req_i(m1_req_i),
      .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i),
      .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
      .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
      .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
      .m_rdata_o(m_rdata_o),
      .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o),
      .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i),
      .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
      .busy_o(busy_o)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops expectations whenever the DUT grants or memory returns a response.
   always @(negedge clk) begin
      if (!rst) begin
         if (m0_gnt_o || m1_gnt_o) begin
            if (gnt_q.size() == 0) begin
               check("unexpected_gnt", {30'b0, m1_gnt_o, m0_gnt_o}, 32'h0);
            end else begin
               gnt_t g;
               g = gnt_q.pop_front();
               check("gnt_onehot", {30'b0, m1_gnt_o, m0_gnt_o}, g.id ? 32'h2 : 32'h1);
               check("gnt_addr", obi_addr_o, g.addr);
            end
         end
         if (obi_rvalid_i) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_rsp", 32'h1, 32'h0);
            end else begin
               rsp_t r;
               r = rsp_q.pop_front();
               if (r.vld) begin
                  check("rsp_rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o}, r.id ? 32'h2 : 32'h1);
                  check("rsp_err", {30'b0, m1_err_o, m0_err_o},
                        r.id ? {30'b0, r.err, 1'b0} : {31'b0, r.err});
                  check("rsp_rdata", m_rdata_o, r.data);
               end else begin
                  check("rsp_dropped", {30'b0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
               end
            end
         end else begin
            check("rvalid_idle", {30'b0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
         end
      end
   end

   task automatic drive(input logic r0, input logic r1, input logic g, input logic rv,
                        input logic e, input logic [31:0] rd);
      m0_req_i = r0; m1_req_i = r1; obi_gnt_i = g;
      obi_rvalid_i = rv; obi_err_i = e; obi_rdata_i = rd;
   endtask

   task automatic exp_gnt(input logic id);
      gnt_t g;
      g.id = id; g.addr = id ? A1 : A0;
      gnt_q.push_back(g);
   endtask

   task automatic exp_rsp(input logic vld, input logic id, input logic err, input logic [31:0] d);
      rsp_t r;
      r.vld = vld; r.id = id; r.err = err; r.data = d;
      rsp_q.push_back(r);
   endtask

   task automatic cyc(input string nm, input logic exp_req);
      @(negedge clk);
      check(nm, {31'b0, obi_req_o}, {31'b0, exp_req});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      m0_addr_i = A0;
      m1_addr_i = A1;
      drive(1, 1, 1, 1, 1, 32'hDEAD_BEEF);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_req", {31'b0, obi_req_o}, 32'h0);
         check("rst_gnt", {30'b0, m1_gnt_o, m0_gnt_o}, 32'h0);
         check("rst_rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
         check("rst_busy", {31'b0, busy_o}, 32'h0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;

      // First tie after reset goes to master 0
      drive(1, 1, 1, 0, 0, 32'h0);
      exp_gnt(0);
      cyc("t1_req", 1);

      // Round-robin with one-cycle response latency
      for (int i = 1; i <= 4; i++) begin
         drive(1, 1, 1, 1, 0, 32'hA0 + i);
         exp_gnt(1'(i % 2));
         exp_rsp(1, 1'((i - 1) % 2), 0, 32'hA0 + i);
         cyc("t2_req", 1);
      end
      drive(0, 0, 0, 1, 0, 32'hB0);
      exp_rsp(1, 0, 0, 32'hB0);
      cyc("t2_drain", 0);
      drive(0, 0, 0, 0, 0, 32'h0);
      @(negedge clk);
      check("t2_idle_busy", {31'b0, busy_o}, 32'h0);
      @(posedge clk);
      #1;

      // Lock: master 1 waits for gnt while master 0 starts requesting
      for (int i = 0; i < 3; i++) begin
         drive(i > 0, 1, 0, 0, 0, 32'h0);
         @(negedge clk);
         check("t3_req", {31'b0, obi_req_o}, 32'h1);
         check("t3_addr", obi_addr_o, A1);
         @(posedge clk);
         #1;
      end
      drive(1, 1, 1, 0, 0, 32'h0);
      exp_gnt(1);
      cyc("t3_gnt_m1", 1);
      drive(1, 1, 1, 0, 0, 32'h0);
      exp_gnt(0);
      cyc("t3_gnt_m0", 1);

      // Full stall: two outstanding (m1, m0)
      drive(1, 1, 1, 0, 0, 32'h0);
      cyc("t4_full", 0);
      drive(1, 1, 1, 1, 0, 32'hC1);
      exp_rsp(1, 1, 0, 32'hC1);
      cyc("t4_full_pop", 0);
      drive(1, 1, 1, 0, 0, 32'h0);
      exp_gnt(1);
      cyc("t4_resume", 1);
      drive(0, 0, 0, 1, 0, 32'hC2);
      exp_rsp(1, 0, 0, 32'hC2);
      cyc("t4_drain0", 0);
      drive(0, 0, 0, 1, 0, 32'hC3);
      exp_rsp(1, 1, 0, 32'hC3);
      cyc("t4_drain1", 0);

      // Simultaneous push/pop with error
      drive(1, 0, 1, 0, 0, 32'h0);
      exp_gnt(0);
      cyc("t5_gnt_m0", 1);
      drive(0, 1, 1, 1, 1, 32'hD1);
      exp_gnt(1);
      exp_rsp(1, 0, 1, 32'hD1);
      cyc("t5_pushpop", 1);
      drive(0, 0, 0, 1, 0, 32'hD2);
      exp_rsp(1, 1, 0, 32'hD2);
      cyc("t5_last_rsp", 0);
      drive(0, 0, 0, 0, 0, 32'h0);
      @(negedge clk);
      check("t5_idle_busy", {31'b0, busy_o}, 32'h0);
      @(posedge clk);
      #1;

      // Reset with two outstanding, then a late response
      drive(1, 0, 1, 0, 0, 32'h0);
      exp_gnt(0);
      cyc("t6_gnt_m0", 1);
      drive(0, 1, 1, 0, 0, 32'h0);
      exp_gnt(1);
      cyc("t6_gnt_m1", 1);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(0, 0, 0, 1, 0, 32'hE1);
      exp_rsp(0, 0, 0, 32'h0);
      @(negedge clk);
      check("t6_late_busy", {31'b0, busy_o}, 32'h0);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 32'h0);
      @(negedge clk);
      check("t6_after_busy", {31'b0, busy_o}, 32'h0);
      @(posedge clk);
      #1;

      check("gnt_queue_empty", gnt_q.size(), 32'h0);
      check("rsp_queue_empty", rsp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cv32e41p_instr_obi_arbiter.md
# cv32e41p_instr_obi_arbiter

Two-master arbiter that shares the core's single OBI instruction port between the prefetch buffer's OBI interface (master 0) and a secondary instruction-side requester (master 1, e.g. a debug program-buffer fetcher). It sits between those masters and the instruction memory or cache. It serialises address phases, keeps each address phase stable until granted, and tracks the owner of every outstanding transaction so that each response returns to the master that issued it. Request and response paths are combinational; ownership, lock and fairness state are registered.

## Interface
- `MAX_OUTSTANDING`, default 2: depth of the owner FIFO, i.e. the maximum number of granted but unanswered transactions. Must be ≥1 and a power of 2.
- `ARB_MODE`, default 0: 0 = round-robin, 1 = fixed priority with master 0 highest.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: **synchronous, active-high reset**.
- `m0_req_i`, `m1_req_i`, in, 1 each: master address-phase request.
- `m0_addr_i`, `m1_addr_i`, in, 32 each: master word address.
- `m0_gnt_o`, `m1_gnt_o`, out, 1 each: master grant.
- `m0_rvalid_o`, `m1_rvalid_o`, out, 1 each: master response valid.
- `m0_err_o`, `m1_err_o`, out, 1 each: master response error, qualified by that master's rvalid.
- `m_rdata_o`, out, 32: response data, broadcast to both masters.
- `obi_req_o`, out, 1: request to memory.
- `obi_addr_o`, out, 32: address to memory.
- `obi_gnt_i`, in, 1: grant from memory.
- `obi_rvalid_i`, in, 1: response valid from memory.
- `obi_rdata_i`, in, 32: response data from memory.
- `obi_err_i`, in, 1: response error from memory.
- `busy_o`, out, 1: high when any transaction is outstanding or `obi_req_o` is high.

## Operation
**State**
- Owner FIFO: `MAX_OUTSTANDING` entries of 1 bit (the owner ID), plus a count from 0 to `MAX_OUTSTANDING`.
- `lock_q` and `lock_id_q`: held while an address phase is pending without a grant.
- `last_q`: ID of the last granted master.

**Selection**
- If `lock_q` = 1: `sel = lock_id_q`.
- Else, in `ARB_MODE` 0:
  - only one master requesting → select it;
  - both requesting → select `!last_q`.
- Else, in `ARB_MODE` 1: select master 0 if `m0_req_i`, otherwise master 1.

**Address phase**
- `obi_req_o = req[sel] && !full`.
- `obi_addr_o = addr[sel]`.
- `gnt[sel] = obi_gnt_i && obi_req_o`. The non-selected master's gnt is 0.
- Full blocks new requests even if `obi_rvalid_i` pops the FIFO in the same cycle. There is no rvalid→req combinational path.

**Lock**
- `lock_q` is set to 1, with `lock_id_q = sel`, when `obi_req_o && !obi_gnt_i`.
- `lock_q` is cleared on grant.
- The lock is also held while `full` blocks the pending request. In that case `lock_q` is set when `req[sel] && full`.
- Effect: the selection never switches mid address phase (OBI stability).

**Handshake**
- On `obi_req_o && obi_gnt_i`: push `sel` into the FIFO and set `last_q <= sel`.

**Response**
- On `obi_rvalid_i` with a non-empty FIFO: pop the head.
- `m<head>_rvalid_o = 1`. `m<head>_err_o = obi_err_i`.
- `m_rdata_o = obi_rdata_i` at all times.

**Simultaneous push and pop**
- The count is unchanged. The head advances and the new entry is written at the tail.

**Protocol violation**
- `obi_rvalid_i` with an empty FIFO: the response is dropped and both rvalids stay 0. The bench flags this as an error.

**Reset**
- Values after reset: FIFO count = 0, `lock_q` = 0, `last_q` = 1 (so master 0 wins the first round-robin tie).
- While `rst` is high, all outputs are 0.
- A reset mid-operation discards the outstanding ownership. Late responses that arrive after reset fall under the empty-FIFO drop rule.

## Timing
- Request → `obi_req_o`: 0 cycles, combinational.
- `obi_gnt_i` → `mX_gnt_o`: 0 cycles.
- `obi_rvalid_i` → `mX_rvalid_o`: 0 cycles.
- Back-to-back grants are allowed every cycle until the FIFO is full. Throughput is 1 transaction per cycle with a zero-wait memory.
- The FIFO push and pop, `lock_q` and `last_q` update on the rising edge after the event.
- `busy_o` is combinational from the count and `obi_req_o`.
- Responses return strictly in issue order; OBI guarantees in-order responses.

## Test plan
1. **Reset values:** assert `rst` for 2 cycles with both requests high → `obi_req_o` = 0 and all grants and rvalids = 0. On the first cycle after reset, with both requesting and `ARB_MODE` = 0, master 0 is granted (`obi_addr_o` = `m0_addr_i` = `0x0000_1000`).
2. **Round-robin:** both masters request continuously, `obi_gnt_i` = 1 and rvalid returned one cycle later → grants alternate 0,1,0,1 and each rvalid pulse reaches the issuing master only.
3. **Lock:** master 1 is selected with `obi_gnt_i` = 0 for 3 cycles while master 0 raises its request → `obi_addr_o` stays at master 1's `0x0000_2004` until the grant. Master 0 is granted in the next cycle.
4. **Full stall:** `MAX_OUTSTANDING` = 2, two grants with no rvalid → a third request gives `obi_req_o` = 0. With rvalid in that same cycle, `obi_req_o` stays 0 and rises on the next cycle.
5. **Simultaneous push/pop plus error:** count = 1 (owner master 0), a new master 1 grant coincides with rvalid and `obi_err_i` = 1 → `m0_rvalid_o` = 1 and `m0_err_o` = 1, the count stays 1, and the next rvalid goes to master 1.
6. **Reset mid-operation:** reset with 2 outstanding, then `obi_rvalid_i` = 1 → no master rvalid is asserted and the count stays 0.
